vend_ctrl: RTL

VEND_CTRL -- requirements
Module: vend_ctrl

---
 rtl/vend_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/vend_ctrl.sv
// Vending machine controller: coin credit, drink dispense and change return.
// Optional VEND_TIMEOUT_EN refunds the drink price if delivery is never confirmed.
module vend_ctrl #(
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 7,
    parameter int TIMEOUT    = 15
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       coin,
    input  logic       cancel,
    input  logic       selection,
    input  logic       received,
    output logic       flash,
    output logic       drink,
    output logic       change,
    output logic       reject,
    output logic       accept,
    output logic [3:0] credit
);

    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

    localparam logic [3:0] PRICE_U = 4'(PRICE);
    localparam logic [3:0] MAX_U   = 4'(MAX_CREDIT);

    state_t     state, state_next;
    logic [3:0] credit_next;
    logic       reject_next;

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] timer, timer_next;
    logic [4:0]    refund_sum;
    logic [3:0]    refund_credit;

    assign refund_sum    = {1'b0, credit} + 5'(PRICE);
    assign refund_credit = (refund_sum > 5'd15) ? 4'd15 : refund_sum[3:0];
`else
    // TIMEOUT only matters when the timeout feature is compiled in
    if (TIMEOUT < 1) begin : g_timeout_out_of_range
    end
`endif

    always_comb begin
        state_next  = state;
        credit_next = credit;
        reject_next = 1'b0;
`ifdef VEND_TIMEOUT_EN
        timer_next  = '0;
`endif
        case (state)
            IDLE: begin
                if (coin) begin
                    credit_next = 4'd1;
                    state_next  = CREDIT;
                end
            end
            CREDIT: begin
                if (coin) begin
                    if (credit < MAX_U) credit_next = credit + 4'd1;
                    else                reject_next = 1'b1;
                end
                // A coin arriving with cancel is counted first, so it is refunded too
                if (cancel) begin
                    state_next = CHANGE;
                end else if (selection && credit >= PRICE_U) begin
                    credit_next = credit_next - PRICE_U;
                    state_next  = VEND;
                end
            end
            VEND: begin
`ifdef VEND_TIMEOUT_EN
                timer_next = timer + 1'b1;
`endif
                if (received) begin
                    state_next = (credit != 4'd0) ? CHANGE : IDLE;
`ifdef VEND_TIMEOUT_EN
                end else if (timer == TIMER_LAST) begin
                    credit_next = refund_credit;
                    state_next  = CHANGE;
`endif
                end
            end
            CHANGE: begin
                credit_next = (credit != 4'd0) ? credit - 4'd1 : 4'd0;
                if (credit <= 4'd1) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
`ifdef VEND_TIMEOUT_EN
        if (state_next != VEND) timer_next = '0;
`endif
    end

    // Outputs are decoded from the next state so they come straight from flops
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            credit <= 4'd0;
            flash  <= 1'b1;
            drink  <= 1'b0;
            change <= 1'b0;
            reject <= 1'b0;
            accept <= 1'b1;
        end else begin
            state  <= state_next;
            credit <= credit_next;
            flash  <= (state_next == IDLE);
            drink  <= (state_next == VEND);
            change <= (state_next == CHANGE);
            reject <= reject_next;
            accept <= (state_next == IDLE) || (state_next == CREDIT);
        end
    end

`ifdef VEND_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) timer <= '0;
        else         timer <= timer_next;
    end
`endif

endmodule
